// File: rtl/dmem_copier_pkg.sv
// Shared types and constants for the dmem_copier block-copy engine.
package dmem_copier_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} copier_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_copier.sv
// dmem_copier: bus initiator that copies a block of words inside the data memory.
// Define FILL_MODE_EN to add the fill/fill_value ports that write a constant instead of copying.
module dmem_copier
  import dmem_copier_pkg::*;
#(
  parameter int Nloc  = 64,
  parameter int Dbits = 32,
  localparam int AW = $clog2(Nloc) + 2,
  localparam int CW = $clog2(Nloc) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    src_addr,
  input  logic [AW-1:0]    dst_addr,
  input  logic [CW-1:0]    count,
`ifdef FILL_MODE_EN
  input  logic             fill,
  input  logic [Dbits-1:0] fill_value,
`endif
  output logic             busy,
  output logic             done,
  output logic             mem_wr,
  output logic [AW-1:0]    mem_addr,
  output logic [Dbits-1:0] mem_din,
  input  logic [Dbits-1:0] mem_dout
);

  localparam logic [AW-1:0] ADDR_MASK = ~AW'(WORD_BYTES - 1);

  copier_state_t    r_state;
  copier_state_t    w_next_state;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [CW-1:0]    r_count;
  logic [Dbits-1:0] r_data;
  logic             w_start_fill;
  logic             w_fill_active;

`ifdef FILL_MODE_EN
  logic r_fill;
  assign w_start_fill  = fill;
  assign w_fill_active = r_fill;
`else
  assign w_start_fill  = 1'b0;
  assign w_fill_active = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Addresses wrap modulo the memory size because the registers are exactly AW bits wide.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_data  <= '0;
`ifdef FILL_MODE_EN
      r_fill  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_src   <= src_addr & ADDR_MASK;
            r_dst   <= dst_addr & ADDR_MASK;
            r_count <= count;
`ifdef FILL_MODE_EN
            r_fill  <= fill;
            if (fill) begin
              r_data <= fill_value;
            end
`endif
          end
        end
        READ: begin
          r_data <= mem_dout;
        end
        WRITE: begin
          r_src   <= r_src + AW'(WORD_BYTES);
          r_dst   <= r_dst + AW'(WORD_BYTES);
          r_count <= r_count - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            w_next_state = FINISH;
          end else if (w_start_fill) begin
            w_next_state = WRITE;
          end else begin
            w_next_state = READ;
          end
        end
      end
      READ: begin
        w_next_state = WRITE;
      end
      WRITE: begin
        if (r_count > CW'(1)) begin
          w_next_state = w_fill_active ? WRITE : READ;
        end else begin
          w_next_state = FINISH;
        end
      end
      FINISH: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Reset gates the outputs directly so a write in flight during the reset cycle never lands.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (!reset) begin
      case (r_state)
        READ: begin
          busy     = 1'b1;
          mem_addr = r_src;
        end
        WRITE: begin
          busy     = 1'b1;
          mem_wr   = 1'b1;
          mem_addr = r_dst;
          mem_din  = r_data;
        end
        FINISH: begin
          done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
